// File: rtl/key_entry_buffer_if.sv
// Front-panel control bundle and downstream handoff for key_entry_buffer.
interface key_entry_buffer_if #(
  parameter int WIDTH_OUT = 128,
  parameter int WIDTH_IN  = 8
);
  localparam int CHUNKS = WIDTH_OUT / WIDTH_IN;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic [WIDTH_IN-1:0]  d_in;
  logic                 capture_key;
  logic                 clear_chunk;
  logic                 left_shift;
  logic                 right_shift;
  logic                 start;
  logic                 unlock;
  logic                 out_ready;
  logic [WIDTH_OUT-1:0] d_out;
  logic [CW-1:0]        cursor;
  logic [CHUNKS-1:0]    fill_mask;
  logic                 all_filled;
  logic                 out_valid;
  logic                 locked;

  modport master (
    output d_in, capture_key, clear_chunk, left_shift, right_shift,
           start, unlock, out_ready,
    input  d_out, cursor, fill_mask, all_filled, out_valid, locked
  );

  modport slave (
    input  d_in, capture_key, clear_chunk, left_shift, right_shift,
           start, unlock, out_ready,
    output d_out, cursor, fill_mask, all_filled, out_valid, locked
  );
endinterface

// File: rtl/key_entry_buffer.sv
// Chunk-by-chunk key word editor with edge-detected controls, fill tracking
// and a valid/ready handoff that locks the word while downstream uses it.
module key_entry_buffer #(
  parameter int WIDTH_OUT    = 128,
  parameter int WIDTH_IN     = 8,
  parameter int WRAP         = 0,
  parameter int AUTO_ADV     = 0,
  parameter int REQUIRE_FULL = 1
) (
  input logic               clk,
  input logic               rst,
  key_entry_buffer_if.slave bus
);
  localparam int CHUNKS = WIDTH_OUT / WIDTH_IN;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  typedef enum logic [1:0] {EDIT, OFFER, LOCKED} state_t;

  state_t               state, state_n;
  logic [WIDTH_OUT-1:0] word, word_n;
  logic [CW-1:0]        cur, cur_n;
  logic [CHUNKS-1:0]    fill, fill_n;
  logic                 valid_q, locked_q, full_q;
  // Control bit order: {unlock, start, right, left, clear, capture}
  logic [5:0]           ctl, hist, rise;
  logic                 start_ok;

  function automatic logic [CW-1:0] cur_up(input logic [CW-1:0] c);
    if (c == LAST) return (WRAP != 0) ? '0 : LAST;
    return c + 1'b1;
  endfunction

  function automatic logic [CW-1:0] cur_down(input logic [CW-1:0] c);
    if (c == '0) return (WRAP != 0) ? LAST : '0;
    return c - 1'b1;
  endfunction

  assign ctl = {bus.unlock, bus.start, bus.right_shift, bus.left_shift,
                bus.clear_chunk, bus.capture_key};
  assign rise = ctl & ~hist;
  // Start eligibility looks at the fill state before this cycle's edit.
  assign start_ok = (REQUIRE_FULL == 0) || (&fill);

  // Next-state and next-contents: one edit per cycle, start pre-empts edits.
  always_comb begin
    state_n = state;
    word_n  = word;
    cur_n   = cur;
    fill_n  = fill;
    case (state)
      EDIT: begin
        if (rise[4] && start_ok) begin
          state_n = OFFER;
        end else if (rise[0]) begin
          word_n[int'(cur)*WIDTH_IN +: WIDTH_IN] = bus.d_in;
          fill_n[cur] = 1'b1;
          if (AUTO_ADV != 0) cur_n = cur_up(cur);
        end else if (rise[1]) begin
          word_n[int'(cur)*WIDTH_IN +: WIDTH_IN] = '0;
          fill_n[cur] = 1'b0;
        end else if (rise[2]) begin
          cur_n = cur_up(cur);
        end else if (rise[3]) begin
          cur_n = cur_down(cur);
        end
      end
      OFFER: begin
        if (bus.out_ready)  state_n = LOCKED;
        else if (rise[5])   state_n = EDIT;
      end
      LOCKED: begin
        if (rise[5]) state_n = EDIT;
      end
      default: state_n = EDIT;
    endcase
  end

  // State, contents, edge history and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EDIT;
      word     <= '0;
      cur      <= '0;
      fill     <= '0;
      hist     <= '1;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state    <= state_n;
      word     <= word_n;
      cur      <= cur_n;
      fill     <= fill_n;
      hist     <= ctl;
      valid_q  <= (state_n == OFFER);
      locked_q <= (state_n == LOCKED);
      full_q   <= &fill_n;
    end
  end

  assign bus.d_out      = word;
  assign bus.cursor     = cur;
  assign bus.fill_mask  = fill;
  assign bus.all_filled = full_q;
  assign bus.out_valid  = valid_q;
  assign bus.locked     = locked_q;
endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: three parameter flavours driven in lockstep
// and compared every cycle against a chunk-array reference model.
module tb_key_entry_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [5:0] ctl = 6'h00;  // {unlock, start, right, left, clear, capture}
  logic       rdy = 1'b0;

  localparam logic [5:0] CAP = 6'h01, CLR = 6'h02, LFT = 6'h04,
                         RGT = 6'h08, STA = 6'h10, UNL = 6'h20;

  // Instance flavours: A wraps no/adv no/full yes, B wrap/no adv/no full,
  // C no wrap/auto advance/full required.
  localparam int P_WRAP [3] = '{0, 1, 0};
  localparam int P_ADV  [3] = '{0, 0, 1};
  localparam int P_RF   [3] = '{1, 0, 1};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  key_entry_buffer_if #(.WIDTH_OUT(128), .WIDTH_IN(8)) ia ();
  key_entry_buffer_if #(.WIDTH_OUT(128), .WIDTH_IN(8)) ib ();
  key_entry_buffer_if #(.WIDTH_OUT(128), .WIDTH_IN(8)) ic ();

  assign ia.d_in = d_in;  assign ib.d_in = d_in;  assign ic.d_in = d_in;
  assign ia.capture_key = ctl[0]; assign ib.capture_key = ctl[0]; assign ic.capture_key = ctl[0];
  assign ia.clear_chunk = ctl[1]; assign ib.clear_chunk = ctl[1]; assign ic.clear_chunk = ctl[1];
  assign ia.left_shift  = ctl[2]; assign ib.left_shift  = ctl[2]; assign ic.left_shift  = ctl[2];
  assign ia.right_shift = ctl[3]; assign ib.right_shift = ctl[3]; assign ic.right_shift = ctl[3];
  assign ia.start       = ctl[4]; assign ib.start       = ctl[4]; assign ic.start       = ctl[4];
  assign ia.unlock      = ctl[5]; assign ib.unlock      = ctl[5]; assign ic.unlock      = ctl[5];
  assign ia.out_ready   = rdy;    assign ib.out_ready   = rdy;    assign ic.out_ready   = rdy;

  key_entry_buffer #(.WIDTH_OUT(128), .WIDTH_IN(8), .WRAP(0), .AUTO_ADV(0), .REQUIRE_FULL(1))
    u_a (.clk(clk), .rst(rst), .bus(ia));
  key_entry_buffer #(.WIDTH_OUT(128), .WIDTH_IN(8), .WRAP(1), .AUTO_ADV(0), .REQUIRE_FULL(0))
    u_b (.clk(clk), .rst(rst), .bus(ib));
  key_entry_buffer #(.WIDTH_OUT(128), .WIDTH_IN(8), .WRAP(0), .AUTO_ADV(1), .REQUIRE_FULL(1))
    u_c (.clk(clk), .rst(rst), .bus(ic));

  logic [127:0] o_dout [3];
  logic [3:0]   o_cur  [3];
  logic [15:0]  o_fill [3];
  logic         o_full [3];
  logic         o_vld  [3];
  logic         o_lck  [3];

  assign o_dout[0] = ia.d_out;      assign o_dout[1] = ib.d_out;      assign o_dout[2] = ic.d_out;
  assign o_cur[0]  = ia.cursor;     assign o_cur[1]  = ib.cursor;     assign o_cur[2]  = ic.cursor;
  assign o_fill[0] = ia.fill_mask;  assign o_fill[1] = ib.fill_mask;  assign o_fill[2] = ic.fill_mask;
  assign o_full[0] = ia.all_filled; assign o_full[1] = ib.all_filled; assign o_full[2] = ic.all_filled;
  assign o_vld[0]  = ia.out_valid;  assign o_vld[1]  = ib.out_valid;  assign o_vld[2]  = ic.out_valid;
  assign o_lck[0]  = ia.locked;     assign o_lck[1]  = ib.locked;     assign o_lck[2]  = ic.locked;

  // Reference model: a key as sixteen byte slots, an integer cursor,
  // and a mode number (0 editing, 1 offered, 2 locked).
  logic [7:0]  m_chunk [3][16];
  int          m_cur   [3];
  logic [15:0] m_fill  [3];
  int          m_mode  [3];
  logic [5:0]  m_prev;

  function automatic int step_up(input int c, input int wrap);
    return (c == 15) ? ((wrap != 0) ? 0 : 15) : c + 1;
  endfunction

  function automatic int step_down(input int c, input int wrap);
    return (c == 0) ? ((wrap != 0) ? 15 : 0) : c - 1;
  endfunction

  function automatic logic [127:0] m_word(input int i);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[k*8 +: 8] = m_chunk[i][k];
    return w;
  endfunction

  task automatic model_step();
    logic [5:0] pressed;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 16; k++) m_chunk[i][k] = 8'h00;
        m_cur[i] = 0; m_fill[i] = 16'h0000; m_mode[i] = 0;
      end
      m_prev = 6'h3F;
    end else begin
      pressed = ctl & ~m_prev;
      m_prev  = ctl;
      for (int i = 0; i < 3; i++) begin
        if (m_mode[i] == 0) begin
          if (pressed[4] && (P_RF[i] == 0 || m_fill[i] == 16'hFFFF)) m_mode[i] = 1;
          else if (pressed[0]) begin
            m_chunk[i][m_cur[i]] = d_in;
            m_fill[i][m_cur[i]] = 1'b1;
            if (P_ADV[i] != 0) m_cur[i] = step_up(m_cur[i], P_WRAP[i]);
          end else if (pressed[1]) begin
            m_chunk[i][m_cur[i]] = 8'h00;
            m_fill[i][m_cur[i]] = 1'b0;
          end else if (pressed[2]) m_cur[i] = step_up(m_cur[i], P_WRAP[i]);
          else if (pressed[3]) m_cur[i] = step_down(m_cur[i], P_WRAP[i]);
        end else if (m_mode[i] == 1) begin
          if (rdy) m_mode[i] = 2;
          else if (pressed[5]) m_mode[i] = 0;
        end else begin
          if (pressed[5]) m_mode[i] = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("d_out[%0d]", i),      o_dout[i], m_word(i));
      check($sformatf("cursor[%0d]", i),     128'(o_cur[i]), 128'(m_cur[i]));
      check($sformatf("fill_mask[%0d]", i),  128'(o_fill[i]), 128'(m_fill[i]));
      check($sformatf("all_filled[%0d]", i), 128'(o_full[i]), 128'(m_fill[i] == 16'hFFFF));
      check($sformatf("out_valid[%0d]", i),  128'(o_vld[i]), 128'(m_mode[i] == 1));
      check($sformatf("locked[%0d]", i),     128'(o_lck[i]), 128'(m_mode[i] == 2));
    end
  endtask

  // One clock: model follows the edge, outputs checked mid-low-phase.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; ctl = 6'h00; rdy = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic pulse(input logic [5:0] m);
    ctl = m;
    cycle();
    ctl = 6'h00;
    cycle();
  endtask

  logic [127:0] exp_w;

  initial begin
    @(negedge clk);

    // Reset state and a first capture.
    do_reset();
    check("rst_dout", o_dout[0], 128'h0);
    check("rst_cur", 128'(o_cur[0]), 128'h0);
    d_in = 8'hA5;
    ctl = CAP;
    cycle();
    check("cap1_dout", o_dout[0], 128'hA5);
    check("cap1_fill", 128'(o_fill[0]), 128'h0001);
    check("cap1_cur", 128'(o_cur[0]), 128'h0);
    ctl = 6'h00;
    cycle();

    // Cursor limits, saturating (A) versus wrapping (B).
    do_reset();
    for (int k = 0; k < 15; k++) pulse(LFT);
    check("sat_cur15", 128'(o_cur[0]), 128'd15);
    pulse(LFT);
    check("sat_hold15", 128'(o_cur[0]), 128'd15);
    check("wrap_to0", 128'(o_cur[1]), 128'd0);
    pulse(RGT);
    check("wrap_to15", 128'(o_cur[1]), 128'd15);
    do_reset();
    pulse(RGT);
    check("sat_hold0", 128'(o_cur[0]), 128'd0);

    // Held capture writes once; then auto-advance fill on C.
    d_in = 8'h99;
    ctl = CAP;
    repeat (5) cycle();
    check("held_cur", 128'(o_cur[2]), 128'd1);
    check("held_fill", 128'(o_fill[2]), 128'h0001);
    ctl = 6'h00;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      d_in = 8'(k);
      pulse(CAP);
    end
    check("adv_dout", o_dout[2], 128'h0F0E0D0C0B0A09080706050403020100);
    check("adv_full", 128'(o_full[2]), 128'd1);
    check("adv_cur", 128'(o_cur[2]), 128'd15);

    // Start gating on A, offer freeze, acceptance, unlock.
    do_reset();
    exp_w = '0;
    for (int k = 0; k < 15; k++) begin
      d_in = 8'(k + 16);
      exp_w[k*8 +: 8] = 8'(k + 16);
      pulse(CAP);
      pulse(LFT);
    end
    check("partial_fill", 128'(o_fill[0]), 128'h7FFF);
    pulse(STA);
    check("start_blocked", 128'(o_vld[0]), 128'd0);
    d_in = 8'hEE;
    exp_w[127:120] = 8'hEE;
    pulse(CAP);
    ctl = STA;
    cycle();
    check("offer_vld", 128'(o_vld[0]), 128'd1);
    ctl = 6'h00;
    for (int j = 0; j < 3; j++) begin
      d_in = 8'($urandom);
      ctl = (j % 2 == 0) ? CAP : 6'h00;
      cycle();
      check("offer_frozen", o_dout[0], exp_w);
    end
    ctl = 6'h00;
    rdy = 1'b1;
    cycle();
    check("accept_vld", 128'(o_vld[0]), 128'd0);
    check("accept_lck", 128'(o_lck[0]), 128'd1);
    rdy = 1'b0;
    pulse(UNL);
    check("unlock_lck", 128'(o_lck[0]), 128'd0);
    check("unlock_keep", o_dout[0], exp_w);

    // Reset in the middle of an offer, with capture held through it.
    pulse(STA);
    check("reoffer_vld", 128'(o_vld[0]), 128'd1);
    rst = 1'b1;
    ctl = CAP;
    cycle();
    rst = 1'b0;
    check("rst_offer_vld", 128'(o_vld[0]), 128'd0);
    check("rst_offer_dout", o_dout[0], 128'h0);
    repeat (2) cycle();
    check("held_thru_rst", o_dout[0], 128'h0);
    ctl = 6'h00;
    cycle();
    d_in = 8'h3C;
    pulse(CAP);
    check("repress", o_dout[0], 128'h3C);

    // Simultaneous capture+left, then clear, at cursor 2.
    do_reset();
    pulse(LFT);
    pulse(LFT);
    d_in = 8'h77;
    pulse(CAP | LFT);
    check("prio_dout", o_dout[0], 128'h77 << 16);
    check("prio_cur", 128'(o_cur[0]), 128'd2);
    pulse(CLR);
    check("clr_dout", o_dout[0], 128'h0);
    check("clr_fill", 128'(o_fill[0]), 128'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      d_in = 8'($urandom);
      for (int b = 0; b < 6; b++) begin
        if ($urandom_range(0, (b == 1) ? 11 : 3) == 0) ctl[b] = ~ctl[b];
      end
      rdy = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
